// File: rtl/avg_calc_pkg.sv
// Shared definitions for the averaging unit: the controller state encoding
// and the default number of samples per average, which the controller and
// the datapath both use.
package avg_calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ACCUM,
    SHIFT,
    DONE
  } avg_state_t;

  localparam int AVG_N_DEFAULT = 4;

endpackage

// File: rtl/average_calc_controller.sv
// Control FSM for the average-calculator datapath. After a start request it
// clears the datapath, then collects exactly N samples over a valid/ready
// handshake. Next it triggers the divide-by-N shift and pulses done for one
// cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      request a new average (sampled only in IDLE)
//   abort      synchronous cancel, returns to IDLE from any state
//   in_valid   producer presents a sample on the datapath input
//   in_ready   controller accepts a sample this cycle (ACCUM)
//   load       datapath: accumulate the input sample
//   init_sum   datapath: clear accumulator
//   init_shift datapath: clear result register
//   shift      datapath: result <= rounded accumulator >> log2(N)
//   busy       high in every state except IDLE
//   done       one-cycle pulse, datapath result valid from this cycle
module average_calc_controller
  import avg_calc_pkg::*;
#(
  parameter int N = AVG_N_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic in_valid,
  output logic in_ready,
  output logic load,
  output logic init_sum,
  output logic init_shift,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("average_calc_controller: N must be a power of two >= 2");
  end

  avg_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    load       = 1'b0;
    init_sum   = 1'b0;
    init_shift = 1'b0;
    shift      = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (start && !abort) state_next = INIT;
      end
      INIT: begin
        // Clears still happen on an aborted INIT so the datapath is left clean.
        init_sum   = 1'b1;
        init_shift = 1'b1;
        cnt_next   = '0;
        state_next = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        load     = in_valid & ~abort;
        if (load) begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = SHIFT;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      SHIFT: begin
        shift      = ~abort;
        state_next = DONE;
      end
      DONE: begin
        done       = ~abort;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // abort overrides every transition above
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

endmodule

// File: tb/tb_average_calc_controller.sv
module tb_average_calc_controller;

  localparam int N = 4;

  // {load, shift, done, busy, in_ready, init_sum, init_shift}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_INIT  = 7'b0001011;
  localparam logic [6:0] O_LOAD  = 7'b1001100;
  localparam logic [6:0] O_WAIT  = 7'b0001100;
  localparam logic [6:0] O_SHIFT = 7'b0101000;
  localparam logic [6:0] O_DONE  = 7'b0011000;
  localparam logic [6:0] O_ABSH  = 7'b0001000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] inputx = 8'h00;
  logic       in_ready, load, init_sum, init_shift, shift, busy, done;
  logic [6:0] outs;

  always #5 clk = ~clk;

  average_calc_controller #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load       (load),
    .init_sum   (init_sum),
    .init_shift (init_shift),
    .shift      (shift),
    .busy       (busy),
    .done       (done)
  );

  assign outs = {load, shift, done, busy, in_ready, init_sum, init_shift};

  // Datapath model, m=8: rounded mean of N samples.
  logic [11:0] acc;
  logic [7:0]  result;
  always @(posedge clk) begin
    if (init_sum) acc <= '0;
    else if (load) acc <= acc + {4'h0, inputx};
    if (init_shift) result <= '0;
    else if (shift) result <= 8'((acc + 12'd2) >> 2);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       s, a, v;
    logic [7:0] x;
    logic [6:0] exp_o;
    bit         push;
    logic [7:0] push_res;
    int         push_lat;
    bit         rchk;
    logic [7:0] rexp;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } sb_t;

  vec_t  vecs[$];
  sb_t   sb[$];
  sb_t   mon_e;
  int    checks = 0;
  int    failures = 0;
  int    pidx = 0;
  string phase = "reset";

  function automatic vec_t row(input logic s, input logic a, input logic v,
                               input logic [7:0] x, input logic [6:0] e);
    vec_t r;
    r.s = s; r.a = a; r.v = v; r.x = x; r.exp_o = e;
    r.push = 1'b0; r.push_res = '0; r.push_lat = 0;
    r.rchk = 1'b0; r.rexp = '0;
    return r;
  endfunction

  task automatic add(input vec_t r);
    vecs.push_back(r);
  endtask

  // One complete run: gap stall cycles between consecutive samples,
  // poke drives start throughout the busy phase (must be ignored).
  task automatic add_run(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input int gap, input bit poke, input logic [7:0] res);
    vec_t r;
    logic [7:0] smp [4];
    smp = '{a, b, c, d};
    r = row(1, 0, 0, 8'h00, O_IDLE);
    r.push = 1'b1; r.push_res = res; r.push_lat = N + 3 + 3 * gap;
    add(r);
    add(row(0, 0, 1, 8'hEE, O_INIT));
    for (int i = 0; i < 4; i++) begin
      r = row(poke, 0, 1, smp[i], O_LOAD);
      if (i == 0) begin r.rchk = 1'b1; r.rexp = 8'h00; end
      add(r);
      if (i < 3) for (int g = 0; g < gap; g++) add(row(poke, 0, 0, 8'hEE, O_WAIT));
    end
    add(row(poke, 0, 0, 8'h00, O_SHIFT));
    add(row(poke, 0, 0, 8'h00, O_DONE));
    r = row(0, 0, 0, 8'h00, O_IDLE);
    r.rchk = 1'b1; r.rexp = res;
    add(r);
  endtask

  task automatic apply(input vec_t r);
    @(negedge clk);
    start = r.s; abort = r.a; in_valid = r.v; inputx = r.x;
    #1;
    checks++;
    if (outs !== r.exp_o) begin
      failures++;
      $display("FAIL %s outputs cyc=%0d: got %b expected %b", phase, cyc, outs, r.exp_o);
    end
    if (r.rchk) begin
      checks++;
      if (result !== r.rexp) begin
        failures++;
        $display("FAIL %s result cyc=%0d: got %0d expected %0d", phase, cyc, result, r.rexp);
      end
    end
    if (r.push) sb.push_back('{res: r.push_res, cyc: cyc + r.push_lat});
  endtask

  task automatic play();
    for (int i = pidx; i < vecs.size(); i++) apply(vecs[i]);
    pidx = vecs.size();
  endtask

  task automatic check_outs(input string name, input logic [6:0] e);
    checks++;
    if (outs !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, outs, e);
    end
  endtask

  // Scoreboard: every done pulse must match the next queued run.
  always @(negedge clk) begin
    #2;
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done cyc=%0d result=%0d expected no done", cyc, result);
      end else begin
        mon_e = sb.pop_front();
        if (result !== mon_e.res || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL done_result: got result=%0d cyc=%0d expected result=%0d cyc=%0d",
                   result, cyc, mon_e.res, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    // Table: nominal run, stalled run, start poked mid-run, then 255s.
    add_run(8'd10, 8'd20, 8'd30, 8'd40, 0, 1'b0, 8'd25);
    add_run(8'd1,  8'd2,  8'd2,  8'd2,  3, 1'b0, 8'd2);
    add_run(8'd5,  8'd6,  8'd7,  8'd8,  0, 1'b1, 8'd7);
    add_run(8'd255, 8'd255, 8'd255, 8'd255, 0, 1'b0, 8'd255);

    // Reset asserted asynchronously with start/in_valid high.
    start = 1'b1; in_valid = 1'b1;
    #1 rst = 1'b1;
    #1 check_outs("reset_async", O_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset_hold", O_IDLE);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;

    phase = "table";
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    pidx = vecs.size();

    phase = "abort_init";
    add(row(1, 0, 0, 8'h00, O_IDLE));
    add(row(0, 1, 1, 8'hEE, O_INIT));
    add(row(0, 0, 1, 8'hEE, O_IDLE));
    play();

    phase = "abort_after_2";
    add(row(1, 0, 0, 8'h00, O_IDLE));
    add(row(0, 0, 1, 8'd99, O_INIT));
    add(row(0, 0, 1, 8'd99, O_LOAD));
    add(row(0, 0, 1, 8'd99, O_LOAD));
    add(row(1, 1, 1, 8'd99, O_WAIT));
    begin vec_t r; r = row(0, 0, 1, 8'd99, O_IDLE); r.rchk = 1'b1; r.rexp = 8'd0; add(r); end
    add_run(8'd8, 8'd8, 8'd8, 8'd9, 0, 1'b0, 8'd8);
    play();

    phase = "abort_4th";
    add(row(1, 0, 0, 8'h00, O_IDLE));
    add(row(0, 0, 1, 8'd50, O_INIT));
    for (int i = 0; i < 3; i++) add(row(0, 0, 1, 8'd50, O_LOAD));
    add(row(0, 1, 1, 8'd50, O_WAIT));
    begin vec_t r; r = row(0, 0, 1, 8'd50, O_IDLE); r.rchk = 1'b1; r.rexp = 8'd0; add(r); end
    add(row(0, 0, 0, 8'h00, O_IDLE));
    play();

    phase = "abort_shift";
    add(row(1, 0, 0, 8'h00, O_IDLE));
    add(row(0, 0, 1, 8'd60, O_INIT));
    for (int i = 0; i < 4; i++) add(row(0, 0, 1, 8'd60, O_LOAD));
    add(row(0, 1, 0, 8'h00, O_ABSH));
    begin vec_t r; r = row(0, 0, 0, 8'h00, O_IDLE); r.rchk = 1'b1; r.rexp = 8'd0; add(r); end
    add(row(0, 0, 0, 8'h00, O_IDLE));
    play();

    phase = "reset_mid_accum";
    add(row(1, 0, 0, 8'h00, O_IDLE));
    add(row(0, 0, 1, 8'd4, O_INIT));
    add(row(0, 0, 1, 8'd4, O_LOAD));
    add(row(0, 0, 1, 8'd4, O_LOAD));
    play();
    @(negedge clk);
    in_valid = 1'b1; inputx = 8'd4;
    #1 check_outs("pre_reset_load", O_LOAD);
    #2 rst = 1'b1;
    #1 check_outs("reset_mid_accum", O_IDLE);
    @(negedge clk);
    check_outs("reset_mid_hold", O_IDLE);
    rst = 1'b0; in_valid = 1'b0;
    phase = "after_reset";
    add_run(8'd4, 8'd4, 8'd4, 8'd4, 0, 1'b0, 8'd4);
    play();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_done: got %0d outstanding runs expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
